rgb_fade_sequencer: RTL and testbench

//  N-channel LED fade sequencer: ramps a PWM duty level up, holds, ramps down, then

---
 rtl/rgb_seq_pkg.sv | 21 ++
 rtl/pwm_compare.sv | 17 +
 rtl/rgb_fade_sequencer.sv | 165 ++++++++++++++++
 tb/tb_rgb_fade_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared FSM encoding and mode constants for the RGB fade sequencer.
package rgb_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RISE = 2'd1,
    ST_HOLD = 2'd2,
    ST_FALL = 2'd3
  } fsm_state_e;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_ALL    = 2'd1;
  localparam logic [1:0] MODE_XFADE  = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  // Reserved mode behaves as single-channel.
  function automatic logic [1:0] mode_norm(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_SINGLE : m;
  endfunction

endpackage

// File: rtl/pwm_compare.sv
// Registered PWM comparator: duty is high while the shared counter is below the level.
module pwm_compare #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] cnt,
  input  logic [BITS-1:0] level,
  output logic            duty
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) duty <= 1'b0;
    else        duty <= (cnt < level);
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// N-channel LED fade sequencer: rise/hold/fall ramp per channel with single,
// all-together and crossfade PWM modes, enable gating and a cycle-done strobe.
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned PRESCALER  = 0,
  parameter int unsigned HOLD_STEPS = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [1:0]                  mode,
  output logic [CHANNELS-1:0]         pwm_out,
  output logic [$clog2(CHANNELS)-1:0] channel_sel,
  output logic [PWM_BITS-1:0]         level,
  output logic                        cycle_done
);

  localparam int unsigned SEL_W  = $clog2(CHANNELS);
  localparam int unsigned PRE_W  = (PRESCALER > 0) ? $clog2(PRESCALER + 1) : 1;
  localparam int unsigned HOLD_W = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;

  localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
  localparam logic [SEL_W-1:0]    SEL_LAST  = SEL_W'(CHANNELS - 1);
  localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALER);
  localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS);

  fsm_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] level_d;
  logic [SEL_W-1:0]    sel_d;
  logic                done_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [1:0]          mode_q, mode_d;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick_c;
  logic                run_c;
  logic [SEL_W-1:0]    next_sel_c;
  logic [PWM_BITS-1:0] lvl_c [CHANNELS];

  assign tick_c     = (state_q != ST_IDLE) && (presc_q == PRE_LAST);
  assign run_c      = enable && (state_q != ST_IDLE);
  assign next_sel_c = (channel_sel == SEL_LAST) ? '0 : channel_sel + SEL_W'(1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      level       <= '0;
      channel_sel <= '0;
      cycle_done  <= 1'b0;
      presc_q     <= '0;
      hold_q      <= '0;
      mode_q      <= MODE_SINGLE;
    end else begin
      state_q     <= state_d;
      level       <= level_d;
      channel_sel <= sel_d;
      cycle_done  <= done_d;
      presc_q     <= presc_d;
      hold_q      <= hold_d;
      mode_q      <= mode_d;
    end
  end

  // Shared PWM counter wraps naturally at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_cnt <= '0;
    else        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Next-state logic: ramp advances only on step ticks; enable low overrides everything.
  always_comb begin
    state_d = state_q;
    level_d = level;
    sel_d   = channel_sel;
    done_d  = 1'b0;
    hold_d  = hold_q;
    mode_d  = mode_q;
    presc_d = (state_q == ST_IDLE || tick_c) ? '0 : presc_q + PRE_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        level_d = '0;
        if (enable) begin
          state_d = ST_RISE;
          mode_d  = mode_norm(mode);
        end
      end
      ST_RISE: begin
        if (tick_c) begin
          if (level == LVL_MAX) begin
            state_d = ST_HOLD;
            hold_d  = '0;
          end else begin
            level_d = level + PWM_BITS'(1);
          end
        end
      end
      ST_HOLD: begin
        if (tick_c) begin
          if (hold_q == HOLD_LAST) state_d = ST_FALL;
          else                     hold_d  = hold_q + HOLD_W'(1);
        end
      end
      ST_FALL: begin
        if (tick_c) begin
          if (level == '0) begin
            state_d = ST_RISE;
            sel_d   = next_sel_c;
            done_d  = (channel_sel == SEL_LAST);
            mode_d  = mode_norm(mode);
          end else begin
            level_d = level - PWM_BITS'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d = ST_IDLE;
      level_d = '0;
      sel_d   = channel_sel;
      done_d  = 1'b0;
      presc_d = '0;
      hold_d  = hold_q;
      mode_d  = mode_q;
    end
  end

  // Per-channel duty level selected by the latched mode.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      lvl_c[k] = '0;
      if (run_c) begin
        unique case (mode_q)
          MODE_ALL: lvl_c[k] = level;
          MODE_XFADE: begin
            if (channel_sel == SEL_W'(k))     lvl_c[k] = level;
            else if (next_sel_c == SEL_W'(k)) lvl_c[k] = LVL_MAX - level;
          end
          default: begin
            if (channel_sel == SEL_W'(k)) lvl_c[k] = level;
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pwm
    pwm_compare #(
      .BITS(PWM_BITS)
    ) u_pwm (
      .clk  (clk),
      .rst_n(rst_n),
      .cnt  (pwm_cnt),
      .level(lvl_c[g]),
      .duty (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench: two sequencer configurations driven with shared enable/mode,
// each cycle checked against an independent behavioural model.
module tb_rgb_fade_sequencer;

  localparam int CH_A = 3, PB_A = 4, PRE_A = 0, HS_A = 2;
  localparam int CH_B = 5, PB_B = 4, PRE_B = 3, HS_B = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [2:0] pwm_a;
  logic [1:0] sel_a;
  logic [3:0] lvl_a;
  logic       done_a;
  logic [4:0] pwm_b;
  logic [2:0] sel_b;
  logic [3:0] lvl_b;
  logic       done_b;

  int vectors = 0;
  int miscompares = 0;
  int done_b_seen = 0;

  typedef struct {
    int         st;
    int         lvl;
    int         sel;
    int         hold;
    int         pc;
    int         mq;
    int         pwm;
    logic       done;
    logic [7:0] pout;
  } ms_t;

  ms_t ma, mb;
  ms_t qa[$];
  ms_t qb[$];

  rgb_fade_sequencer #(.CHANNELS(CH_A), .PWM_BITS(PB_A), .PRESCALER(PRE_A), .HOLD_STEPS(HS_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .pwm_out(pwm_a), .channel_sel(sel_a), .level(lvl_a), .cycle_done(done_a)
  );

  rgb_fade_sequencer #(.CHANNELS(CH_B), .PWM_BITS(PB_B), .PRESCALER(PRE_B), .HOLD_STEPS(HS_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
    .pwm_out(pwm_b), .channel_sel(sel_b), .level(lvl_b), .cycle_done(done_b)
  );

  always #5 clk = ~clk;

  function automatic ms_t mzero();
    ms_t s;
    s.st = 0; s.lvl = 0; s.sel = 0; s.hold = 0; s.pc = 0; s.mq = 0; s.pwm = 0;
    s.done = 1'b0; s.pout = 8'h00;
    return s;
  endfunction

  // Behavioural model: state after one clock edge given the inputs before it.
  function automatic ms_t mstep(input ms_t s, input bit en, input int md,
                                input int ch, input int pb, input int pre, input int hs);
    ms_t n;
    int  mx, nx, lk;
    bit  tick;
    n    = s;
    mx   = (1 << pb) - 1;
    nx   = (s.sel + 1) % ch;
    tick = (s.st != 0) && (s.pc == pre);
    n.pout = 8'h00;
    if (en && s.st != 0) begin
      for (int k = 0; k < ch; k++) begin
        lk = 0;
        if (s.mq == 1) lk = s.lvl;
        else if (s.mq == 2) begin
          if (k == s.sel) lk = s.lvl;
          else if (k == nx) lk = mx - s.lvl;
        end else if (k == s.sel) lk = s.lvl;
        n.pout[k] = (s.pwm < lk);
      end
    end
    n.pwm  = (s.pwm == mx) ? 0 : s.pwm + 1;
    n.done = 1'b0;
    if (!en) begin
      n.st = 0; n.lvl = 0; n.pc = 0;
    end else begin
      n.pc = (s.st == 0 || tick) ? 0 : s.pc + 1;
      case (s.st)
        0: begin n.st = 1; n.mq = (md == 3) ? 0 : md; end
        1: if (tick) begin
             if (s.lvl == mx) begin n.st = 2; n.hold = 0; end
             else n.lvl = s.lvl + 1;
           end
        2: if (tick) begin
             if (s.hold == hs) n.st = 3;
             else n.hold = s.hold + 1;
           end
        default: if (tick) begin
             if (s.lvl == 0) begin
               n.st = 1; n.sel = nx; n.done = (s.sel == ch - 1);
               n.mq = (md == 3) ? 0 : md;
             end else n.lvl = s.lvl - 1;
           end
      endcase
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    vectors++;
    assert (obs === req) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pwm_a"}, 32'(pwm_a), 32'd0);
    chk({tag, "_sel_a"}, 32'(sel_a), 32'd0);
    chk({tag, "_lvl_a"}, 32'(lvl_a), 32'd0);
    chk({tag, "_done_a"}, 32'(done_a), 32'd0);
    chk({tag, "_pwm_b"}, 32'(pwm_b), 32'd0);
    chk({tag, "_lvl_b"}, 32'(lvl_b), 32'd0);
  endtask

  // Push model predictions, clock once, pop and compare against both DUTs.
  task automatic run(input int n);
    ms_t ea, eb;
    for (int i = 0; i < n; i++) begin
      ma = mstep(ma, enable, int'(mode), CH_A, PB_A, PRE_A, HS_A);
      mb = mstep(mb, enable, int'(mode), CH_B, PB_B, PRE_B, HS_B);
      qa.push_back(ma);
      qb.push_back(mb);
      @(posedge clk);
      #1;
      ea = qa.pop_front();
      eb = qb.pop_front();
      chk("a_pwm", 32'(pwm_a), 32'(ea.pout));
      chk("a_lvl", 32'(lvl_a), 32'(ea.lvl));
      chk("a_sel", 32'(sel_a), 32'(ea.sel));
      chk("a_done", 32'(done_a), 32'(ea.done));
      chk("b_pwm", 32'(pwm_b), 32'(eb.pout));
      chk("b_lvl", 32'(lvl_b), 32'(eb.lvl));
      chk("b_sel", 32'(sel_b), 32'(eb.sel));
      chk("b_done", 32'(done_b), 32'(eb.done));
      chk("b_sel_range", 32'(sel_b <= 3'd4), 32'd1);
      if (done_b) done_b_seen++;
    end
  endtask

  initial begin
    int  guard;
    bit  found;
    ma = mzero();
    mb = mzero();

    // Power-on reset and idle until enabled.
    #1;
    check_all_zero("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    run(4);

    // Single mode through a full three-channel cycle, then mode changes mid-ramp.
    enable = 1'b1;
    mode   = 2'd0;
    run(110);
    mode = 2'd1;
    run(80);
    mode = 2'd2;
    run(120);
    mode = 2'd3;
    run(40);

    // Async reset while A is mid-rise.
    mode  = 2'd0;
    found = 1'b0;
    guard = 0;
    while (!found && guard < 200) begin
      if (ma.st == 1 && ma.lvl >= 5) found = 1'b1;
      else run(1);
      guard++;
    end
    chk("reach_mid_rise", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    ma = mzero();
    mb = mzero();
    @(posedge clk); #1;
    check_all_zero("rst_held");
    enable = 1'b0;
    rst_n  = 1'b1;
    run(5);

    // Crossfade, then drop enable on the edge where A would wrap.
    enable = 1'b1;
    mode   = 2'd2;
    found  = 1'b0;
    guard  = 0;
    while (!found && guard < 400) begin
      if (ma.st == 3 && ma.lvl == 0 && ma.pc == PRE_A && ma.sel == CH_A - 1) found = 1'b1;
      else run(1);
      guard++;
    end
    chk("reach_wrap", 32'(found), 32'd1);
    enable = 1'b0;
    run(1);
    chk("wrap_no_done", 32'(done_a), 32'd0);
    chk("wrap_sel_kept", 32'(sel_a), 32'd2);
    chk("wrap_pwm_off", 32'(pwm_a), 32'd0);
    run(3);

    // Long run so the prescaled five-channel instance wraps.
    enable      = 1'b1;
    mode        = 2'd0;
    done_b_seen = 0;
    run(1400);
    chk("b_cycle_done_seen", 32'(done_b_seen > 0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
